// File: rtl/my_display_controller_pkg.sv
// Shared constants, FSM encoding and helpers for the display controller.
// Optional leading-zero blanking: MY_DISPLAY_CONTROLLER_LZB_EN.
package my_display_controller_pkg;

  localparam int MY_DISPLAY_CONTROLLER_DIGITS    = 4;
  localparam int MY_DISPLAY_CONTROLLER_BIN_WIDTH = 14;
  localparam int MY_ENCODER_DECIMAL_DIGIT_WIDTH  = 4;
  localparam int MY_ENCODER_ENCODING_WIDTH       = 8;

  localparam logic [3:0] MY_DISPLAY_CONTROLLER_BLANK = 4'hF;

  typedef enum logic [1:0] {
    MY_DISPLAY_CONTROLLER_IDLE    = 2'd0,
    MY_DISPLAY_CONTROLLER_CONVERT = 2'd1,
    MY_DISPLAY_CONTROLLER_UPDATE  = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/my_encoder.sv
// BCD digit to active-low seven-segment pattern (bit 7 = dp, kept off).
// Codes above 9 (including the blank code 4'hF) light nothing.
module my_encoder
  import my_display_controller_pkg::*;
#(
  parameter int DECIMAL_DIGIT_WIDTH = MY_ENCODER_DECIMAL_DIGIT_WIDTH,
  parameter int ENCODING_WIDTH      = MY_ENCODER_ENCODING_WIDTH
) (
  input  logic [DECIMAL_DIGIT_WIDTH-1:0] digit,
  output logic [ENCODING_WIDTH-1:0]      segments
);

  logic [3:0] d4;
  logic [7:0] seg;

  assign d4 = 4'(digit);

  always_comb begin
    seg = 8'hFF;
    case (d4)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  end

  assign segments = ENCODING_WIDTH'(seg);

endmodule

// File: rtl/my_display_controller.sv
// Binary to multi-digit seven-segment display via iterative double-dabble.
// Optional leading-zero blanking: MY_DISPLAY_CONTROLLER_LZB_EN.
module my_display_controller
  import my_display_controller_pkg::*;
#(
  parameter int DIGITS              = MY_DISPLAY_CONTROLLER_DIGITS,
  parameter int BIN_WIDTH           = MY_DISPLAY_CONTROLLER_BIN_WIDTH,
  parameter int DECIMAL_DIGIT_WIDTH = MY_ENCODER_DECIMAL_DIGIT_WIDTH,
  parameter int ENCODING_WIDTH      = MY_ENCODER_ENCODING_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               value_valid,
  input  logic [BIN_WIDTH-1:0]               value,
  output logic                               value_ready,
  output logic                               busy,
  output logic                               overflow,
  output logic [DIGITS*ENCODING_WIDTH-1:0]   hex
);

  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam bit OVF_POSSIBLE =
    (BIN_WIDTH >= 64) || ((64'd1 << BIN_WIDTH) > LIMIT);

  typedef logic [DECIMAL_DIGIT_WIDTH-1:0] digit_t;

  state_t                  state, state_next;
  logic [SR_W-1:0]         sr, sr_next;
  logic [BCD_W-1:0]        bcd_adj, bcd;
  logic [CNT_W-1:0]        cnt;
  logic                    ovf_pend, ovf_now, accept, last;
  logic [63:0]             value_ext;
  logic [DIGITS-1:0][DECIMAL_DIGIT_WIDTH-1:0] disp, load;
  logic                    seen;
  logic [3:0]              nib;

  assign accept    = value_valid && value_ready;
  assign last      = (cnt == CNT_W'(BIN_WIDTH - 1));
  assign value_ext = 64'(value);
  assign ovf_now   = OVF_POSSIBLE && (value_ext >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MY_DISPLAY_CONTROLLER_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    value_ready = 1'b0;
    busy        = 1'b0;
    case (state)
      MY_DISPLAY_CONTROLLER_IDLE: begin
        value_ready = 1'b1;
        if (value_valid) state_next = MY_DISPLAY_CONTROLLER_CONVERT;
      end
      MY_DISPLAY_CONTROLLER_CONVERT: begin
        busy = 1'b1;
        if (last) state_next = MY_DISPLAY_CONTROLLER_UPDATE;
      end
      MY_DISPLAY_CONTROLLER_UPDATE: begin
        busy       = 1'b1;
        state_next = MY_DISPLAY_CONTROLLER_IDLE;
      end
      default: state_next = MY_DISPLAY_CONTROLLER_IDLE;
    endcase
  end

  // One double-dabble step: add-3 correction, then shift left.
  always_comb begin
    bcd_adj = sr[SR_W-1 -: BCD_W];
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_adj[k*4 +: 4] >= 4'd5)
        bcd_adj[k*4 +: 4] = bcd_adj[k*4 +: 4] + 4'd3;
    end
    sr_next = {bcd_adj, sr[BIN_WIDTH-1:0]} << 1;
  end

  // Digits loaded at UPDATE; scanned from the top so blanking knows
  // whether a nonzero digit has been seen yet.
  always_comb begin
    bcd  = sr[SR_W-1 -: BCD_W];
    load = '0;
    seen = 1'b0;
    nib  = 4'd0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib = bcd[k*4 +: 4];
      if (ovf_pend) begin
        load[k] = digit_t'(MY_DISPLAY_CONTROLLER_BLANK);
      end else begin
`ifdef MY_DISPLAY_CONTROLLER_LZB_EN
        if (k != 0 && !seen && nib == 4'd0)
          load[k] = digit_t'(MY_DISPLAY_CONTROLLER_BLANK);
        else
          load[k] = digit_t'(nib);
`else
        load[k] = digit_t'(nib);
`endif
      end
      seen = seen | (nib != 4'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
`ifdef MY_DISPLAY_CONTROLLER_LZB_EN
        disp[k] <= (k == 0) ? digit_t'(0)
                            : digit_t'(MY_DISPLAY_CONTROLLER_BLANK);
`else
        disp[k] <= digit_t'(0);
`endif
      end
    end else begin
      case (state)
        MY_DISPLAY_CONTROLLER_IDLE: begin
          if (accept) begin
            sr       <= {{BCD_W{1'b0}}, value};
            cnt      <= '0;
            ovf_pend <= ovf_now;
          end
        end
        MY_DISPLAY_CONTROLLER_CONVERT: begin
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
        end
        MY_DISPLAY_CONTROLLER_UPDATE: begin
          disp     <= load;
          overflow <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_enc
    my_encoder #(
      .DECIMAL_DIGIT_WIDTH (DECIMAL_DIGIT_WIDTH),
      .ENCODING_WIDTH      (ENCODING_WIDTH)
    ) u_enc (
      .digit    (disp[k]),
      .segments (hex[k*ENCODING_WIDTH +: ENCODING_WIDTH])
    );
  end

endmodule

// File: tb/tb_my_display_controller.sv
// Directed self-checking bench for my_display_controller (default params).
// Expected segment words are hand-computed constants.
module tb_my_display_controller;

  logic        clk;
  logic        rst_n;
  logic        value_valid;
  logic [13:0] value;
  logic        value_ready;
  logic        busy;
  logic        overflow;
  logic [31:0] hex;

  int total;
  int bad;
  logic [31:0] shown;

`ifdef MY_DISPLAY_CONTROLLER_LZB_EN
  localparam logic [31:0] HEX_RST  = 32'hFFFFFFC0;
  localparam logic [31:0] HEX_ZERO = 32'hFFFFFFC0;
  localparam logic [31:0] HEX_50   = 32'hFFFF92C0;
  localparam logic [31:0] HEX_7    = 32'hFFFFFFF8;
`else
  localparam logic [31:0] HEX_RST  = 32'hC0C0C0C0;
  localparam logic [31:0] HEX_ZERO = 32'hC0C0C0C0;
  localparam logic [31:0] HEX_50   = 32'hC0C092C0;
  localparam logic [31:0] HEX_7    = 32'hC0C0C0F8;
`endif

  my_display_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_valid (value_valid),
    .value       (value),
    .value_ready (value_ready),
    .busy        (busy),
    .overflow    (overflow),
    .hex         (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Accept v, optionally poke a value mid-conversion or reset mid-way,
  // and check the whole latency window against exp_hex/exp_ovf.
  task automatic convert(input logic [13:0] v, input logic [31:0] exp_hex,
                         input logic exp_ovf, input int poke,
                         input int rst_at);
    int n;
    n = 0;
    @(negedge clk);
    while (!value_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, value_ready}, 32'd1);
    value_valid = 1'b1;
    value       = v;
    @(posedge clk);
    #1;
    value_valid = 1'b0;
    value       = 14'h2AAA;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, value_ready}, 32'd1);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_hex", hex, HEX_RST);
        shown = HEX_RST;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check("busy_cyc", {31'd0, busy}, 32'd1);
      check("ready_low", {31'd0, value_ready}, 32'd0);
      check("hex_hold", hex, shown);
      if (i == poke) begin
        value_valid = 1'b1;
        value       = 14'd5678;
      end else if (i == poke + 1) begin
        value_valid = 1'b0;
        value       = 14'h2AAA;
      end
    end
    @(negedge clk);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_ready", {31'd0, value_ready}, 32'd1);
    check("done_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
    check("done_hex", hex, exp_hex);
    shown = exp_hex;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    value_valid = 1'b0;
    value       = '0;
    shown       = HEX_RST;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_ready", {31'd0, value_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_hex", hex, HEX_RST);

    convert(14'd1234, 32'hF9A4B099, 1'b0, -10, -10);
    convert(14'd9999, 32'h90909090, 1'b0, -10, -10);
    convert(14'd0, HEX_ZERO, 1'b0, -10, -10);
    convert(14'd50, HEX_50, 1'b0, -10, -10);
    convert(14'd10000, 32'hFFFFFFFF, 1'b1, -10, -10);
    convert(14'd16383, 32'hFFFFFFFF, 1'b1, -10, -10);
    convert(14'd7, HEX_7, 1'b0, -10, -10);
    convert(14'd1234, 32'hF9A4B099, 1'b0, 3, -10);
    convert(14'd9, 32'hC0C0C090 | (HEX_7 & 32'hFFFFFF00), 1'b0, -10, -10);
    convert(14'd4321, 32'h0, 1'b0, -10, 7);
    convert(14'd4321, 32'h99B0A4F9, 1'b0, -10, -10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
